calc_alu_sequencer: RTL

Multi-cycle arithmetic sequencer that executes one calculator operation per request for the keypad FSM. It accepts a start pulse with an op code and two unsigned operands. ADD and SUB complete in a single step. MUL runs as a shift-add loop and DIV as a restoring-division loop, one bit per clock, so the datapath needs no combinational multiplier or divider. The block returns a one-cycle done strobe with the result, remainder and error flags.

---
 rtl/calc_alu_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle calculator ALU: single-step ADD/SUB, bit-serial shift-add MUL
// and restoring DIV, with a one-cycle done strobe and sticky result registers.
module calc_alu_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_W-1:0]     operand_a,
  input  logic [DATA_W-1:0]     operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   result,
  output logic [DATA_W-1:0]     remainder,
  output logic                  err_div0,
  output logic                  err_neg,
  output logic                  err_op
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_DIV = 3'd4
  } op_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic [2*DATA_W-1:0]   a_sh_q, a_sh_d;
  logic [DATA_W-1:0]     b_sh_q, b_sh_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]     remainder_q, remainder_d;
  logic                  err_div0_q, err_div0_d;
  logic                  err_neg_q, err_neg_d;
  logic                  err_op_q, err_op_d;

  logic                  fin;
  logic [2*DATA_W-1:0]   fin_res;
  logic [DATA_W-1:0]     fin_rem;
  logic                  fin_div0, fin_neg, fin_op;
  logic [2*DATA_W-1:0]   mul_acc;
  logic [DATA_W:0]       div_rem;
  logic                  div_bit;
  logic [DATA_W-1:0]     div_quo;
  logic                  last_iter;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    remainder_d = remainder_q;
    err_div0_d  = err_div0_q;
    err_neg_d   = err_neg_q;
    err_op_d    = err_op_q;

    fin       = 1'b0;
    fin_res   = '0;
    fin_rem   = '0;
    fin_div0  = 1'b0;
    fin_neg   = 1'b0;
    fin_op    = 1'b0;
    mul_acc   = '0;
    div_rem   = '0;
    div_bit   = 1'b0;
    div_quo   = '0;
    last_iter = (cnt_q == CNT_W'(DATA_W - 1));

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_sh_d  = {{DATA_W{1'b0}}, operand_a};
          b_sh_d  = operand_b;
          acc_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        case (op_q)
          OP_ADD: begin
            fin     = 1'b1;
            fin_res = a_sh_q + {{DATA_W{1'b0}}, b_sh_q};
          end
          OP_SUB: begin
            fin     = 1'b1;
            fin_res = {{DATA_W{1'b0}}, a_sh_q[DATA_W-1:0] - b_sh_q};
            fin_neg = (a_sh_q[DATA_W-1:0] < b_sh_q);
          end
          OP_MUL: begin
            mul_acc = acc_q + (b_sh_q[0] ? a_sh_q : '0);
            acc_d   = mul_acc;
            a_sh_d  = a_sh_q << 1;
            b_sh_d  = b_sh_q >> 1;
            fin     = last_iter;
            fin_res = mul_acc;
          end
          OP_DIV: begin
            if (b_sh_q == '0) begin
              fin      = 1'b1;
              fin_div0 = 1'b1;
            end else begin
              // Partial remainder carries one extra bit so divisors above
              // 2^(DATA_W-1) still compare correctly after the shift.
              div_rem = {rem_q, a_sh_q[DATA_W-1]};
              if (div_rem >= {1'b0, b_sh_q}) begin
                div_rem = div_rem - {1'b0, b_sh_q};
                div_bit = 1'b1;
              end
              div_quo = {a_sh_q[DATA_W-2:0], div_bit};
              rem_d   = div_rem[DATA_W-1:0];
              a_sh_d  = {{DATA_W{1'b0}}, div_quo};
              fin     = last_iter;
              fin_res = {{DATA_W{1'b0}}, div_quo};
              fin_rem = div_rem[DATA_W-1:0];
            end
          end
          default: begin
            fin    = 1'b1;
            fin_op = 1'b1;
          end
        endcase

        if (fin) begin
          result_d    = fin_res;
          remainder_d = fin_rem;
          err_div0_d  = fin_div0;
          err_neg_d   = fin_neg;
          err_op_d    = fin_op;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      err_div0_q  <= 1'b0;
      err_neg_q   <= 1'b0;
      err_op_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      err_div0_q  <= err_div0_d;
      err_neg_q   <= err_neg_d;
      err_op_q    <= err_op_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign remainder = remainder_q;
  assign err_div0  = err_div0_q;
  assign err_neg   = err_neg_q;
  assign err_op    = err_op_q;

endmodule
